// File: rtl/monitor_pkg.sv
// Shared definitions for the monitor hold-off scheduler: FSM encoding,
// default timebase and the saturating hold-off load computation.
package monitor_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    // 1 s per i_compare unit at a 10 kHz clock
    localparam int unsigned TICKS_PER_UNIT_DEF = 10000;

    // ticks * compare, clipped to the largest value a cnt_w-bit counter holds.
    // The product is formed wide enough that it can never wrap before the clip.
    function automatic logic [31:0] calc_load(input logic [3:0]  compare,
                                              input int unsigned ticks,
                                              input int unsigned cnt_w);
        logic [63:0] prod;
        logic [63:0] lim;
        prod = 64'(ticks) * 64'(compare);
        lim  = (64'd1 << cnt_w) - 64'd1;
        if (prod > lim) begin
            prod = lim;
        end
        return prod[31:0];
    endfunction

endpackage

// File: rtl/monitor_edge_detect.sv
// One monitored channel: previous-sample register, polarity-qualified
// invalid-edge pulse and the sticky pending flag owned by the scheduler.
module monitor_edge_detect
    import monitor_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_arm,
    input  logic i_signal,
    input  logic i_polarity,
    input  logic i_set,
    input  logic i_clear,
    output logic o_edge,
    output logic o_pending
);

    logic r_buf_q;
    logic r_buf_d;
    logic pending_q;
    logic pending_d;

    // Edge qualification and pending next-state; a set in the same cycle as a clear wins
    always_comb begin
        r_buf_d   = i_signal;
        o_edge    = i_arm & (r_buf_q != i_signal) & (i_signal == ~i_polarity);
        pending_d = i_set | (pending_q & ~i_clear);
    end

    // Previous sample tracks the input every cycle, reset included, so the
    // level present during reset is the reference for the first compare
    always_ff @(posedge i_clk) begin
        r_buf_q <= r_buf_d;
    end

    // Pending flag register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign o_pending = pending_q;

endmodule

// File: rtl/monitor_holdoff_scheduler.sv
// Multi-channel validity supervisor. Every channel flags itself not-valid on
// an invalid edge; one shared hold-off counter is handed out round-robin and
// a channel is released once its input has stayed quiet for the hold-off.
module monitor_holdoff_scheduler
    import monitor_pkg::*;
#(
    parameter  int unsigned N_CH           = 4,
    parameter  int unsigned CNT_W          = 18,
    parameter  int unsigned TICKS_PER_UNIT = TICKS_PER_UNIT_DEF,
    localparam int unsigned AW             = $clog2(N_CH)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic [N_CH-1:0] i_signal,
    input  logic [N_CH-1:0] i_polarity,
    input  logic [3:0]      i_compare,
    output logic [N_CH-1:0] o_valid,
    output logic            o_busy,
    output logic [AW-1:0]   o_active_ch,
    output logic [7:0]      o_fault_count
);

    logic            prime_q;
    logic            prime_d;
    logic            arm;
    logic [N_CH-1:0] edge_w;
    logic [N_CH-1:0] pending_w;
    logic [N_CH-1:0] clear_vec;

    state_e          state_q;
    state_e          state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [AW-1:0]   active_q;
    logic [AW-1:0]   active_d;
    logic [AW-1:0]   rr_q;
    logic [AW-1:0]   rr_d;
    logic            busy_q;
    logic            busy_d;
    logic [7:0]      fault_q;
    logic [7:0]      fault_d;

    logic [CNT_W-1:0] load_val;
    logic            grant_found;
    logic [AW-1:0]   grant_idx;

    // Detection is masked for the single cycle following reset release
    always_comb begin
        prime_d = 1'b0;
        arm     = i_enable & ~prime_q;
    end

    // Prime flag register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prime_q <= 1'b1;
        end else begin
            prime_q <= prime_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        monitor_edge_detect u_edge (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_arm      (arm),
            .i_signal   (i_signal[c]),
            .i_polarity (i_polarity[c]),
            .i_set      (edge_w[c]),
            .i_clear    (clear_vec[c]),
            .o_edge     (edge_w[c]),
            .o_pending  (pending_w[c])
        );
    end

    // Hold-off length for the current i_compare, clipped to the counter width
    always_comb begin
        load_val = CNT_W'(calc_load(i_compare, TICKS_PER_UNIT, CNT_W));
    end

    // First pending channel at or after the round-robin pointer, wrapping
    always_comb begin : p_grant
        logic [AW:0] sum;
        sum         = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            sum = {1'b0, rr_q} + (AW+1)'(i);
            if (sum >= (AW+1)'(N_CH)) begin
                sum = sum - (AW+1)'(N_CH);
            end
            if (!grant_found && pending_w[sum[AW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[AW-1:0];
            end
        end
    end

    // One fault per cycle with any detected edge, saturating
    always_comb begin
        fault_d = fault_q;
        if ((|edge_w) && (fault_q != 8'hFF)) begin
            fault_d = fault_q + 8'd1;
        end
    end

    // Scheduler next-state: grant in IDLE, count/reload/release in COUNT.
    // A fresh edge on the owner restarts its hold-off even on the terminal cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        rr_d      = rr_q;
        busy_d    = busy_q;
        clear_vec = '0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (grant_found) begin
                    active_d = grant_idx;
                    cnt_d    = load_val;
                    busy_d   = 1'b1;
                    state_d  = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (edge_w[active_q]) begin
                    cnt_d = load_val;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    clear_vec[active_q] = 1'b1;
                    rr_d    = (active_q == AW'(N_CH - 1)) ? '0 : active_q + AW'(1);
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Scheduler, timer and fault counter registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            rr_q     <= '0;
            busy_q   <= 1'b0;
            fault_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            rr_q     <= rr_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    assign o_valid       = ~pending_w;
    assign o_busy        = busy_q;
    assign o_active_ch   = active_q;
    assign o_fault_count = fault_q;

endmodule

// File: tb/tb_monitor_holdoff_scheduler.sv
// Bench for monitor_holdoff_scheduler: directed table, corner sequences and
// randomized traffic checked against a deadline-based reference model.
module tb_monitor_holdoff_scheduler;
    import monitor_pkg::*;

    localparam int N   = 4;
    localparam int CW  = 18;
    localparam int TPU = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] sig;
    logic [3:0] pol;
    logic [3:0] cmp;
    logic [3:0] valid;
    logic       busy;
    logic [1:0] act;
    logic [7:0] fault;

    int n_checks = 0;
    int n_err    = 0;

    monitor_holdoff_scheduler #(
        .N_CH           (N),
        .CNT_W          (CW),
        .TICKS_PER_UNIT (TPU)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .i_signal      (sig),
        .i_polarity    (pol),
        .i_compare     (cmp),
        .o_valid       (valid),
        .o_busy        (busy),
        .o_active_ch   (act),
        .o_fault_count (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    // reference model: pending set, one owner with an absolute release deadline
    int         m_t      = 0;
    logic [3:0] m_prev   = '0;
    logic [3:0] m_pend   = '0;
    logic       m_prime  = 1'b0;
    logic       m_busy   = 1'b0;
    int         m_owner  = 0;
    int         m_rr     = 0;
    int         m_expire = 0;
    int         m_fault  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp_v);
        end
    endtask

    function automatic int mload(input logic [3:0] c);
        longint p;
        p = longint'(TPU) * longint'(c);
        if (p > (longint'(1) << CW) - 1) p = (longint'(1) << CW) - 1;
        return int'(p);
    endfunction

    task automatic model_eval();
        logic [3:0] e;
        logic [3:0] newp;
        if (rst) begin
            m_prev  = sig;
            m_pend  = '0;
            m_prime = 1'b1;
            m_busy  = 1'b0;
            m_owner = 0;
            m_rr    = 0;
            m_fault = 0;
        end else begin
            for (int c = 0; c < N; c++)
                e[c] = !m_prime && en && (m_prev[c] != sig[c]) && (sig[c] == !pol[c]);
            if (e != 0 && m_fault < 255) m_fault++;
            newp = m_pend | e;
            if (m_busy) begin
                if (e[m_owner]) begin
                    m_expire = m_t + 2 + mload(cmp);
                end else if (m_t + 1 == m_expire) begin
                    newp[m_owner] = 1'b0;
                    m_busy = 1'b0;
                    m_rr   = (m_owner + 1) % N;
                end
            end else if (m_pend != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (!m_busy && m_pend[(m_rr + i) % N]) begin
                        m_owner  = (m_rr + i) % N;
                        m_busy   = 1'b1;
                        m_expire = m_t + 2 + mload(cmp);
                    end
                end
            end
            m_pend  = newp;
            m_prev  = sig;
            m_prime = 1'b0;
        end
        m_t++;
    endtask

    task automatic step();
        logic [3:0] ev;
        model_eval();
        @(posedge clk);
        #1;
        ev = ~m_pend;
        chk("model_valid", valid, ev);
        chk("model_busy", busy, m_busy);
        chk("model_active", act, m_owner[1:0]);
        chk("model_fault", fault, m_fault);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] sig;
        logic [3:0] ev;
        logic       eb;
        logic [1:0] ea;
        logic [7:0] ef;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [3:0] mask;
        int         f0;

        // reset with ch0 high, ch1 rising during the prime cycle, then one
        // ch0 rising edge with i_compare=2 (load 8, nine counting cycles)
        tbl[0] = '{1'b1, 4'b0001, 4'b1111, 1'b0, 2'd0, 8'd0};
        tbl[1] = '{1'b1, 4'b0001, 4'b1111, 1'b0, 2'd0, 8'd0};
        tbl[2] = '{1'b0, 4'b0011, 4'b1111, 1'b0, 2'd0, 8'd0};
        tbl[3] = '{1'b0, 4'b0011, 4'b1111, 1'b0, 2'd0, 8'd0};
        tbl[4] = '{1'b0, 4'b0010, 4'b1111, 1'b0, 2'd0, 8'd0};
        tbl[5] = '{1'b0, 4'b0011, 4'b1110, 1'b0, 2'd0, 8'd1};
        for (int r = 6; r <= 14; r++) tbl[r] = '{1'b0, 4'b0011, 4'b1110, 1'b1, 2'd0, 8'd1};
        tbl[15] = '{1'b0, 4'b0011, 4'b1111, 1'b0, 2'd0, 8'd1};

        en  = 1'b1;
        pol = 4'b0000;
        cmp = 4'd2;
        rst = 1'b1;
        sig = 4'b0001;

        chk("load_fn_150000", calc_load(4'd15, 10000, 18), 32'd150000);
        chk("load_fn_saturate", calc_load(4'd15, 10000, 17), 32'd131071);
        chk("load_fn_zero", calc_load(4'd0, 10000, 18), 32'd0);

        for (int r = 0; r < 16; r++) begin
            rst = tbl[r].rst;
            sig = tbl[r].sig;
            step();
            chk($sformatf("tbl%0d_valid", r), valid, tbl[r].ev);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].eb);
            chk($sformatf("tbl%0d_active", r), act, tbl[r].ea);
            chk($sformatf("tbl%0d_fault", r), fault, tbl[r].ef);
        end

        // ch1 and ch3 rise together: ch1 served, one idle cycle, then ch3
        sig = 4'b0001;
        step();
        for (int j = 1; j <= 22; j++) begin
            if (j == 1) sig = 4'b1011;
            step();
            if (j <= 20) chk("pair_ch3_held", valid[3], 1'b0);
            if (j == 1) chk("pair_fault_once", fault, 8'd2);
            if (j == 2) begin
                chk("pair_first_busy", busy, 1'b1);
                chk("pair_first_ch1", act, 2'd1);
            end
            if (j == 11) chk("pair_idle_gap", busy, 1'b0);
            if (j == 12) begin
                chk("pair_second_busy", busy, 1'b1);
                chk("pair_second_ch3", act, 2'd3);
            end
            if (j == 21) begin
                chk("pair_done_busy", busy, 1'b0);
                chk("pair_done_valid", valid, 4'b1111);
            end
        end

        // retrigger on ch0 with the counter at 3
        sig = 4'b1010;
        step();
        f0 = fault;
        for (int j = 1; j <= 18; j++) begin
            if (j == 1) sig = 4'b1011;
            if (j == 7) sig = 4'b1010;
            if (j == 8) sig = 4'b1011;
            step();
            if (j == 8) chk("retrig_fault", fault, f0 + 2);
            if (j == 16) begin
                chk("retrig_still_busy", busy, 1'b1);
                chk("retrig_still_invalid", valid[0], 1'b0);
            end
            if (j == 17) begin
                chk("retrig_release_busy", busy, 1'b0);
                chk("retrig_release_valid", valid[0], 1'b1);
            end
        end

        // edge on the owner in the very cycle its counter reaches zero
        sig = 4'b1010;
        step();
        for (int j = 1; j <= 20; j++) begin
            if (j == 1) sig = 4'b1011;
            if (j == 10) sig = 4'b1010;
            if (j == 11) sig = 4'b1011;
            step();
            if (j == 11 || j == 19) begin
                chk("tie_busy_kept", busy, 1'b1);
                chk("tie_valid_low", valid[0], 1'b0);
            end
            if (j == 20) chk("tie_release", busy, 1'b0);
        end

        // long hold-off interrupted by reset, then a masked edge in the prime cycle
        sig = 4'b1010;
        cmp = 4'd15;
        step();
        sig = 4'b1011;
        step();
        for (int j = 0; j < 5; j++) step();
        chk("long_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        chk("rst_valid", valid, 4'b1111);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fault", fault, 8'd0);
        chk("rst_active", act, 2'd0);
        rst = 1'b0;
        sig = 4'b1111;
        step();
        chk("prime_mask_fault", fault, 8'd0);
        step();
        chk("prime_mask_valid", valid, 4'b1111);

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 1499) == 0);
            en  = ($urandom_range(0, 7) != 0);
            cmp = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) pol = 4'($urandom);
            mask = '0;
            for (int c = 0; c < N; c++) mask[c] = ($urandom_range(0, 5) == 0);
            sig = sig ^ mask;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/monitor_holdoff_scheduler.md
Name: monitor_holdoff_scheduler

Overview:
Multi-channel supervisor for external state signals. Each channel detects edges into its invalid level and flags itself not-valid. A single shared hold-off countdown timer is granted round-robin to pending channels. A channel's valid output returns high only after it has held a stable valid level for the programmed hold-off time. The block sits between the pad inputs and the top-level status outputs, and replaces one counter per channel with one counter shared by all channels.

Parameters:
N_CH, 4, number of monitored channels (2..8)
CNT_W, 18, shared countdown width; must hold 15*TICKS_PER_UNIT
TICKS_PER_UNIT, 10000, clock ticks per i_compare unit (1 s at 10 kHz)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  1 = edge detection armed; 0 = detection masked, hold-offs already running continue
i_signal  in  N_CH  monitored signals, already synchronised upstream
i_polarity  in  N_CH  per channel: 1 = falling edge is invalid; 0 = rising edge is invalid
i_compare  in  4  hold-off length in units; sampled at grant and at each reload
o_valid  out  N_CH  1 = channel valid (no pending or active hold-off)
o_busy  out  1  shared timer owned by a channel
o_active_ch  out  clog2(N_CH)  index of the owning channel; held at its last value when idle
o_fault_count  out  8  saturating count of detected invalid edges, all channels

Behaviour:
- Reset values: o_valid all 1s, o_busy 0, o_active_ch 0, o_fault_count 0, pending 0, counter 0, rr pointer 0, state IDLE.
- Per-channel previous-sample register r_buf. It loads i_signal on every cycle.
- Detection is masked in the first cycle after reset deasserts (prime cycle). A high level present at reset therefore never counts as an edge.
- Invalid edge on channel c = (r_buf[c] != i_signal[c]) and i_signal[c] == ~i_polarity[c], gated by i_enable and the prime cycle.
- Detection in cycle k sets pending[c] in k+1. o_valid[c] is registered and equals ~pending[c], so it falls in k+1.
- o_fault_count increments by 1 per cycle in which any edge is detected, not by the number of channels. It saturates at 255.
- Timer load value = TICKS_PER_UNIT * i_compare. Compute it at CNT_W+4 bits, then saturate to all ones if it exceeds CNT_W.
- FSM state IDLE:
  - If no channel is pending: stay in IDLE, o_busy 0.
  - Otherwise: grant the first pending channel at or after the rr pointer, wrapping around. Load the counter, set o_active_ch, set o_busy 1, move to COUNT.
- FSM state COUNT:
  - A new invalid edge on the active channel reloads the counter. This takes priority over the counter reaching 0, including when both happen in the same cycle.
  - Else if the counter is non-zero, decrement it.
  - Else (counter == 0): clear pending[active], set rr pointer = active+1 mod N_CH, move to IDLE, o_busy 0. o_valid[active] rises in the next cycle.
- Hold time: (load value + 1) COUNT cycles after the last edge. i_compare = 0 gives 1 COUNT cycle.
- Edges on non-active channels only set pending; they never pre-empt the active channel.
- Minimum gap between one release and the next grant: one IDLE cycle.
- i_reset mid-count: all state returns to reset values in the next cycle, and the prime cycle is applied again.

Decomposition:
- Package monitor_pkg holds:
  - the state encoding (IDLE, COUNT);
  - the TICKS_PER_UNIT default;
  - a function that computes the saturating load value.
- Sub-module monitor_edge_detect holds one channel's r_buf, its polarity-qualified edge pulse and its pending flag. It has set and clear inputs, and is instantiated N_CH times.
- Round-robin selection and the shared timer stay in the top module.

Test Plan (sim with TICKS_PER_UNIT=4, N_CH=4, i_enable=1):
- Reset with i_signal=4'b0001 and polarity 0 → no fault and o_valid=4'b1111 through the prime cycle. o_fault_count stays 0.
- ch0, polarity 0, rising edge, i_compare=2 → o_valid[0]=0 one cycle later, o_busy=1, o_active_ch=0. Release after 9 COUNT cycles, then o_valid[0]=1. o_fault_count=1.
- ch1 and ch3 edges in the same cycle → ch1 served first, then ch3 after one IDLE cycle. o_valid[3] stays 0 throughout. o_fault_count increments by 1.
- Retrigger: second ch0 edge 3 cycles before expiry → counter reloads to 8. Release occurs 9 cycles after the second edge.
- Edge arriving in the same cycle the counter hits 0 → reload wins, state stays COUNT, o_valid[0] stays 0.
- i_compare=15 with default TICKS → load value 150000 fits 18 bits. i_reset asserted mid-count → next cycle o_valid=4'b1111, o_busy=0, o_fault_count=0.
